// File: rtl/char_gpu_pkg.sv
// Shared constants and types for the character glyph memory and its scheduler.
package char_gpu_pkg;

  localparam int unsigned NUM_CHARS  = 36;
  localparam int unsigned GLYPH_W    = 4;
  localparam int unsigned GLYPH_H    = 5;
  localparam int unsigned CHAR_IDX_W = 6;
  localparam int unsigned X_W        = $clog2(GLYPH_W);
  localparam int unsigned Y_W        = $clog2(GLYPH_H);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    WR_SETUP,
    WR_STROBE
  } sched_state_t;

  // Side information that travels alongside a read through the array latency.
  typedef struct packed {
    logic                  valid;
    logic [CHAR_IDX_W-1:0] char_idx;
    logic                  in_range;
  } rd_meta_t;

  function automatic logic row_ok(input logic [Y_W-1:0] y);
    return y <= Y_W'(GLYPH_H - 1);
  endfunction

endpackage

// File: rtl/char_read_pipe.sv
// Fixed-latency read return path: aligns read metadata with arr_rdata,
// selects the requested glyph bit and registers the renderer outputs.
module char_read_pipe
  import char_gpu_pkg::*;
#(
  parameter int unsigned NUM_CHARS = char_gpu_pkg::NUM_CHARS,
  parameter int unsigned ARR_LAT   = 1
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  acc,
  input  logic [CHAR_IDX_W-1:0] char_idx,
  input  logic                  in_range,
  input  logic [NUM_CHARS-1:0]  arr_rdata,
  output logic                  busy_c,
  output logic                  disp_valid,
  output logic                  disp_pixel
);

  localparam int unsigned DEPTH = ARR_LAT + 1;

  rd_meta_t pipe_q [DEPTH];
  logic     pixel_c;

  // Stage 0 lines up with arr_x/arr_y; stage ARR_LAT lines up with arr_rdata.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0].valid    <= acc;
      pipe_q[0].char_idx <= char_idx;
      pipe_q[0].in_range <= in_range;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Reads still waiting on the array keep the address bus reserved.
  always_comb begin
    busy_c = 1'b0;
    for (int unsigned i = 0; i < ARR_LAT; i++) begin
      busy_c = busy_c | pipe_q[i].valid;
    end
  end

  always_comb begin
    pixel_c = 1'b0;
    for (int unsigned i = 0; i < NUM_CHARS; i++) begin
      if (pipe_q[ARR_LAT].char_idx == CHAR_IDX_W'(i)) begin
        pixel_c = arr_rdata[i];
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      disp_valid <= 1'b0;
      disp_pixel <= 1'b0;
    end else begin
      disp_valid <= pipe_q[ARR_LAT].valid;
      disp_pixel <= pipe_q[ARR_LAT].valid & pipe_q[ARR_LAT].in_range & pixel_c;
    end
  end

endmodule

// File: rtl/char_glyph_sched.sv
// Glyph memory bus owner: arbitrates renderer reads against host pixel writes,
// sequences the write strobe and returns read bits with fixed latency.
module char_glyph_sched
  import char_gpu_pkg::*;
#(
  parameter int unsigned NUM_CHARS  = char_gpu_pkg::NUM_CHARS,
  parameter int unsigned ARR_LAT    = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  disp_req,
  output logic                  disp_gnt,
  input  logic [CHAR_IDX_W-1:0] disp_char,
  input  logic [X_W-1:0]        disp_col,
  input  logic [Y_W-1:0]        disp_row,
  output logic                  disp_valid,
  output logic                  disp_pixel,
  input  logic                  host_req,
  input  logic [X_W-1:0]        host_x,
  input  logic [Y_W-1:0]        host_y,
  input  logic                  host_bit,
  output logic                  host_ack,
  output logic                  host_err,
  output logic                  arr_write,
  output logic [X_W-1:0]        arr_x,
  output logic [Y_W-1:0]        arr_y,
  output logic                  arr_data,
  input  logic [NUM_CHARS-1:0]  arr_rdata
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  sched_state_t        state_q, state_nx;
  logic [STARVE_W-1:0] starve_q, starve_nx;
  logic                arr_write_nx, host_ack_nx, host_err_nx, arr_data_nx;
  logic [X_W-1:0]      arr_x_nx;
  logic [Y_W-1:0]      arr_y_nx;
  logic                gnt_c, host_pick_c, starved_c, busy_c, rd_in_range_c;

  assign starved_c     = (starve_q == STARVE_W'(STARVE_MAX));
  assign host_pick_c   = host_req & (~disp_req | starved_c);
  assign rd_in_range_c = (32'(disp_char) < NUM_CHARS) & row_ok(disp_row);
  assign disp_gnt      = gnt_c & rst_n;

  // Next-state, grant and next-output decode.
  always_comb begin
    state_nx     = state_q;
    starve_nx    = starve_q;
    gnt_c        = 1'b0;
    arr_write_nx = 1'b0;
    host_ack_nx  = 1'b0;
    host_err_nx  = 1'b0;
    arr_x_nx     = arr_x;
    arr_y_nx     = arr_y;
    arr_data_nx  = arr_data;

    case (state_q)
      IDLE: begin
        if (host_pick_c) begin
          if (busy_c) begin
            state_nx = DRAIN;
          end else begin
            state_nx    = WR_SETUP;
            arr_x_nx    = host_x;
            arr_y_nx    = host_y;
            arr_data_nx = host_bit;
          end
        end else if (disp_req) begin
          gnt_c    = 1'b1;
          arr_x_nx = disp_col;
          arr_y_nx = disp_row;
          if (host_req) begin
            starve_nx = starved_c ? starve_q : starve_q + STARVE_W'(1);
          end else begin
            starve_nx = '0;
          end
        end
      end

      DRAIN: begin
        if (!busy_c) begin
          state_nx    = WR_SETUP;
          arr_x_nx    = host_x;
          arr_y_nx    = host_y;
          arr_data_nx = host_bit;
        end
      end

      WR_SETUP: begin
        state_nx     = WR_STROBE;
        arr_write_nx = row_ok(host_y);
        host_ack_nx  = 1'b1;
        host_err_nx  = ~row_ok(host_y);
      end

      WR_STROBE: begin
        state_nx  = IDLE;
        starve_nx = '0;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      arr_write <= 1'b0;
      host_ack  <= 1'b0;
      host_err  <= 1'b0;
      arr_x     <= '0;
      arr_y     <= '0;
      arr_data  <= 1'b0;
    end else begin
      state_q   <= state_nx;
      starve_q  <= starve_nx;
      arr_write <= arr_write_nx;
      host_ack  <= host_ack_nx;
      host_err  <= host_err_nx;
      arr_x     <= arr_x_nx;
      arr_y     <= arr_y_nx;
      arr_data  <= arr_data_nx;
    end
  end

  char_read_pipe #(
    .NUM_CHARS (NUM_CHARS),
    .ARR_LAT   (ARR_LAT)
  ) u_read_pipe (
    .clock      (clock),
    .rst_n      (rst_n),
    .acc        (disp_gnt),
    .char_idx   (disp_char),
    .in_range   (rd_in_range_c),
    .arr_rdata  (arr_rdata),
    .busy_c     (busy_c),
    .disp_valid (disp_valid),
    .disp_pixel (disp_pixel)
  );

endmodule

// File: tb/tb_char_glyph_sched.sv
// Bench for char_glyph_sched with a broadcast-write glyph array model and a read scoreboard.
`timescale 1ns/1ps
module tb_char_glyph_sched;
  import char_gpu_pkg::*;

  localparam int NCH = 36;

  logic            clock = 1'b0;
  logic            rst_n;
  logic            disp_req, disp_gnt, disp_valid, disp_pixel;
  logic [5:0]      disp_char;
  logic [1:0]      disp_col, host_x, arr_x;
  logic [2:0]      disp_row, host_y, arr_y;
  logic            host_req, host_bit, host_ack, host_err;
  logic            arr_write, arr_data;
  logic [NCH-1:0]  arr_rdata;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int pops   = 0;

  typedef struct packed {
    logic       pix;
    int         cyc;
    logic [5:0] chr;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  logic [31:0] glyph [NCH];

  char_glyph_sched #(.NUM_CHARS(NCH), .ARR_LAT(1), .STARVE_MAX(8)) dut (
    .clock(clock), .rst_n(rst_n),
    .disp_req(disp_req), .disp_gnt(disp_gnt), .disp_char(disp_char),
    .disp_col(disp_col), .disp_row(disp_row),
    .disp_valid(disp_valid), .disp_pixel(disp_pixel),
    .host_req(host_req), .host_x(host_x), .host_y(host_y), .host_bit(host_bit),
    .host_ack(host_ack), .host_err(host_err),
    .arr_write(arr_write), .arr_x(arr_x), .arr_y(arr_y), .arr_data(arr_data),
    .arr_rdata(arr_rdata)
  );

  always #5 clock = ~clock;

  // Array model: one-cycle registered read, write broadcast to every glyph.
  always @(posedge clock) begin
    for (int c = 0; c < NCH; c++) begin
      if (!rst_n) begin
        glyph[c] <= 32'h6B1D_C35A ^ (32'(c) * 32'h0101_0107) | ((c == 0) ? 32'h200 : 32'h0);
      end else begin
        arr_rdata[c] <= glyph[c][{arr_y, arr_x}];
        if (arr_write) glyph[c][{arr_y, arr_x}] <= arr_data;
      end
    end
  end

  // Scoreboard: push on every granted read, pop on every disp_valid.
  always @(negedge clock) begin
    cyc_n = cyc_n + 1;
    if (rst_n) begin
      if (disp_req && disp_gnt) begin
        e_mon.cyc = cyc_n;
        e_mon.chr = disp_char;
        if (disp_char < 6'd36 && disp_row <= 3'd4) e_mon.pix = glyph[disp_char][{disp_row, disp_col}];
        else e_mon.pix = 1'b0;
        sb.push_back(e_mon);
      end
      if (disp_valid) begin
        checks++;
        pops++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_valid: got disp_valid=1 required no pending read");
        end else begin
          e_mon = sb.pop_front();
          if (disp_pixel !== e_mon.pix || (cyc_n - e_mon.cyc) != 3) begin
            errors++;
            $display("FAIL sb_read char=%0d: got pixel=%0d latency=%0d required pixel=%0d latency=3",
                     e_mon.chr, disp_pixel, cyc_n - e_mon.cyc, e_mon.pix);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; disp_req = 1'b1; disp_char = '0; disp_col = '0; disp_row = '0;
    host_req = 1'b0; host_x = '0; host_y = '0; host_bit = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (disp_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: got %0b required 0", disp_gnt);
    end
    checks++;
    if ({disp_valid, disp_pixel, host_ack, host_err, arr_write, arr_data, arr_x, arr_y} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", {disp_valid, disp_pixel, host_ack, host_err, arr_write, arr_data, arr_x, arr_y});
    end
    disp_req = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_read();
    disp_req = 1'b1; disp_char = 6'd0; disp_col = 2'd1; disp_row = 3'd2;
    #1;
    checks++;
    if (disp_gnt !== 1'b1) begin
      errors++; $display("FAIL single_gnt: got %0b required 1", disp_gnt);
    end
    tick();
    disp_req = 1'b0;
    checks++;
    if (arr_x !== 2'd1 || arr_y !== 3'd2) begin
      errors++; $display("FAIL single_addr: got x=%0d y=%0d required x=1 y=2", arr_x, arr_y);
    end
    tick();
    tick();
    checks++;
    if (disp_valid !== 1'b1 || disp_pixel !== 1'b1) begin
      errors++; $display("FAIL single_result: got valid=%0b pixel=%0b required 1 1", disp_valid, disp_pixel);
    end
    tick();
    checks++;
    if (disp_valid !== 1'b0) begin
      errors++; $display("FAIL single_pulse: got valid=%0b required 0", disp_valid);
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      disp_req = 1'b1; disp_char = 6'(i); disp_col = 2'(i); disp_row = 3'(i % 5);
      #1;
      checks++;
      if (disp_gnt !== 1'b1) begin
        errors++; $display("FAIL b2b_gnt idx=%0d: got %0b required 1", i, disp_gnt);
      end
      tick();
    end
    disp_req = 1'b0;
    repeat (5) tick();
    checks++;
    if (pops - p0 != 10 || sb.size() != 0) begin
      errors++; $display("FAIL b2b_count: got %0d pulses pending=%0d required 10 pending=0", pops - p0, sb.size());
    end
  endtask

  task automatic test_host_write();
    disp_req = 1'b0; host_req = 1'b1; host_x = 2'd3; host_y = 3'd4; host_bit = 1'b1;
    tick();
    checks++;
    if (arr_write !== 1'b0 || host_ack !== 1'b0 || arr_x !== 2'd3 || arr_y !== 3'd4 || arr_data !== 1'b1) begin
      errors++;
      $display("FAIL wr_setup: got write=%0b ack=%0b x=%0d y=%0d data=%0b required 0 0 3 4 1", arr_write, host_ack, arr_x, arr_y, arr_data);
    end
    tick();
    checks++;
    if (arr_write !== 1'b1 || host_ack !== 1'b1 || host_err !== 1'b0 || arr_data !== 1'b1) begin
      errors++;
      $display("FAIL wr_strobe: got write=%0b ack=%0b err=%0b data=%0b required 1 1 0 1", arr_write, host_ack, host_err, arr_data);
    end
    host_req = 1'b0;
    tick();
    disp_req = 1'b1; disp_char = 6'd7; disp_col = 2'd3; disp_row = 3'd4;
    #1;
    checks++;
    if (arr_write !== 1'b0 || host_ack !== 1'b0 || disp_gnt !== 1'b1) begin
      errors++; $display("FAIL wr_back_idle: got write=%0b ack=%0b gnt=%0b required 0 0 1", arr_write, host_ack, disp_gnt);
    end
    tick();
    disp_req = 1'b0;
    tick();
    tick();
    checks++;
    if (disp_valid !== 1'b1 || disp_pixel !== 1'b1) begin
      errors++; $display("FAIL wr_readback: got valid=%0b pixel=%0b required 1 1", disp_valid, disp_pixel);
    end
    repeat (2) tick();
  endtask

  task automatic test_starvation();
    int grants = 0, first_low = -1, resume = -1, acks = 0, wr_cyc = -1;
    disp_req = 1'b1; host_req = 1'b1; host_x = 2'd0; host_y = 3'd0; host_bit = 1'b0;
    for (int c = 0; c < 30 && resume < 0; c++) begin
      disp_char = 6'($urandom_range(0, 35));
      disp_col  = 2'($urandom_range(0, 3));
      disp_row  = 3'($urandom_range(0, 4));
      #1;
      if (disp_gnt) begin
        if (first_low < 0) grants++;
        else resume = c;
      end else if (first_low < 0) begin
        first_low = c;
      end
      if (arr_write) wr_cyc = c;
      if (host_ack) begin
        acks++;
        host_req = 1'b0;
      end
      tick();
    end
    disp_req = 1'b0;
    host_req = 1'b0;
    repeat (5) tick();
    checks++;
    if (grants != 8) begin
      errors++; $display("FAIL starve_grants: got %0d required 8", grants);
    end
    checks++;
    if (resume - first_low != 4) begin
      errors++; $display("FAIL starve_stall: got %0d cycles required 4", resume - first_low);
    end
    checks++;
    if (acks != 1 || wr_cyc != first_low + 3) begin
      errors++; $display("FAIL starve_write: got acks=%0d strobe_at=%0d required acks=1 strobe_at=%0d", acks, wr_cyc, first_low + 3);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL starve_drain: got pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_err_and_range();
    disp_req = 1'b0; host_req = 1'b1; host_x = 2'd1; host_y = 3'd6; host_bit = 1'b1;
    tick();
    tick();
    checks++;
    if (host_ack !== 1'b1 || host_err !== 1'b1 || arr_write !== 1'b0) begin
      errors++; $display("FAIL err_strobe: got ack=%0b err=%0b write=%0b required 1 1 0", host_ack, host_err, arr_write);
    end
    host_req = 1'b0;
    tick();
    checks++;
    if (host_err !== 1'b0) begin
      errors++; $display("FAIL err_pulse: got %0b required 0", host_err);
    end
    disp_req = 1'b1; disp_char = 6'd40; disp_col = 2'd2; disp_row = 3'd1;
    tick();
    disp_char = 6'd0; disp_col = 2'd1; disp_row = 3'd5;
    tick();
    disp_req = 1'b0;
    checks++;
    if (arr_x !== 2'd1 || arr_y !== 3'd5) begin
      errors++; $display("FAIL range_addr: got x=%0d y=%0d required x=1 y=5", arr_x, arr_y);
    end
    tick();
    checks++;
    if (disp_valid !== 1'b1 || disp_pixel !== 1'b0) begin
      errors++; $display("FAIL range_char: got valid=%0b pixel=%0b required 1 0", disp_valid, disp_pixel);
    end
    tick();
    checks++;
    if (disp_valid !== 1'b1 || disp_pixel !== 1'b0) begin
      errors++; $display("FAIL range_row: got valid=%0b pixel=%0b required 1 0", disp_valid, disp_pixel);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_in_strobe();
    host_req = 1'b1; host_x = 2'd1; host_y = 3'd1; host_bit = 1'b1;
    tick();
    tick();
    checks++;
    if (arr_write !== 1'b1) begin
      errors++; $display("FAIL rst_pre_strobe: got write=%0b required 1", arr_write);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (arr_write !== 1'b0 || host_ack !== 1'b0 || disp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async: got write=%0b ack=%0b valid=%0b required 0 0 0", arr_write, host_ack, disp_valid);
    end
    host_req = 1'b0;
    sb.delete();
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (dut.state_q !== IDLE || dut.starve_q !== '0) begin
      errors++; $display("FAIL rst_state: got state=%0d starve=%0d required 0 0", dut.state_q, dut.starve_q);
    end
    disp_req = 1'b1; host_req = 1'b1; disp_char = 6'd3; disp_col = 2'd0; disp_row = 3'd0;
    #1;
    checks++;
    if (disp_gnt !== 1'b1) begin
      errors++; $display("FAIL rst_display_wins: got gnt=%0b required 1", disp_gnt);
    end
    tick();
    disp_req = 1'b0;
    host_req = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_host_write();
    test_starvation();
    test_err_and_range();
    test_reset_in_strobe();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL final_drain: got pending=%0d required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
